// File: rtl/io_pkg.sv
// Shared definitions for the memory-mapped board I/O controller:
// register offsets within the window, the switch-interrupt enable bit,
// and the offset decoder used by the bus front end.
package io_pkg;

  localparam logic [7:0] OFF_HEX      = 8'h00;
  localparam logic [7:0] OFF_LEDR     = 8'h04;
  localparam logic [7:0] OFF_LEDG     = 8'h08;
  localparam logic [7:0] OFF_KEY      = 8'h10;
  localparam logic [7:0] OFF_SW       = 8'h14;
  localparam logic [7:0] OFF_KEY_EDGE = 8'h18;
  localparam logic [7:0] OFF_SW_EDGE  = 8'h1C;
  localparam logic [7:0] OFF_IRQ_EN   = 8'h20;

  // Bit of IRQ_EN that enables interrupts from every switch edge.
  localparam int IRQ_SW_BIT = 31;

  typedef enum logic [3:0] {
    REG_HEX,
    REG_LEDR,
    REG_LEDG,
    REG_KEY,
    REG_SW,
    REG_KEY_EDGE,
    REG_SW_EDGE,
    REG_IRQ_EN,
    REG_NONE
  } reg_sel_e;

  // Map a byte offset inside the window onto a register; anything not in
  // the map (including misaligned offsets) selects nothing.
  function automatic reg_sel_e decode_offset(input logic [7:0] off);
    reg_sel_e sel;
    case (off)
      OFF_HEX:      sel = REG_HEX;
      OFF_LEDR:     sel = REG_LEDR;
      OFF_LEDG:     sel = REG_LEDG;
      OFF_KEY:      sel = REG_KEY;
      OFF_SW:       sel = REG_SW;
      OFF_KEY_EDGE: sel = REG_KEY_EDGE;
      OFF_SW_EDGE:  sel = REG_SW_EDGE;
      OFF_IRQ_EN:   sel = REG_IRQ_EN;
      default:      sel = REG_NONE;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/io_debounce.sv
// Per-channel input conditioning: a two-flop synchroniser followed by a
// counter-based debouncer. A channel's stable value only follows the
// synchronised input after it has held a new level for DEBOUNCE_CYCLES
// consecutive clocks. Inputs arrive already normalised so that 0 is the
// inactive level; the synchroniser therefore clears to 0.
module io_debounce #(
  parameter int WIDTH           = 1,
  parameter int DEBOUNCE_CYCLES = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] stable,
  output logic [WIDTH-1:0] toggle
);

  // Counter only has to reach DEBOUNCE_CYCLES-1.
  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] sync1_q, sync2_q;
  logic [WIDTH-1:0] stable_q, stable_d;
  logic [CW-1:0]    cnt_q [WIDTH];
  logic [CW-1:0]    cnt_d [WIDTH];

  // Count consecutive clocks where the synchronised input disagrees with
  // the stable value; accept the new level when the run is long enough.
  always_comb begin
    // NOTE: every combinational output gets a default before any branch,
    // otherwise a path that skips an assignment infers a latch.
    stable_d = stable_q;
    toggle   = '0;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != stable_q[i]) begin
        if (cnt_q[i] == CNT_LAST) begin
          stable_d[i] = sync2_q[i];
          toggle[i]   = 1'b1;
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
  end

  // Synchroniser, counters and stable value; reset drops any pending change.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      stable_q <= '0;
      // NOTE: the counter array is per-channel control state, not storage,
      // so every entry is cleared; a stale count would shorten the first
      // debounce after reset.
      for (int i = 0; i < WIDTH; i++) cnt_q[i] <= '0;
    end else begin
      // NOTE: non-blocking assignments let sync2 take the old sync1 value,
      // which is what makes this a two-stage synchroniser.
      sync1_q  <= din;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      for (int i = 0; i < WIDTH; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign stable = stable_q;

endmodule

// File: rtl/mmio_io_ctrl.sv
// Memory-mapped controller for KEY, SW, HEX, LEDR and LEDG. Claims its own
// 256-byte window on the data bus, debounces the button and switch pins,
// keeps sticky edge-capture registers and raises a level interrupt.
module mmio_io_ctrl
  import io_pkg::*;
#(
  parameter int               DBITS           = 32,
  parameter logic [DBITS-1:0] IO_BASE         = 32'hF000_0000,
  parameter int               NUM_KEYS        = 4,
  parameter int               NUM_SW          = 10,
  parameter int               NUM_LEDR        = 10,
  parameter int               NUM_LEDG        = 8,
  parameter int               HEX_DIGITS      = 4,
  parameter int               KEY_ACTIVE_LOW  = 1,
  parameter int               DEBOUNCE_CYCLES = 50000
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    we,
  input  logic                    re,
  input  logic [DBITS-1:0]        addr,
  input  logic [DBITS-1:0]        wdata,
  output logic [DBITS-1:0]        rdata,
  output logic                    rd_valid,
  input  logic [NUM_KEYS-1:0]     key_in,
  input  logic [NUM_SW-1:0]       sw_in,
  output logic [NUM_LEDR-1:0]     ledr_out,
  output logic [NUM_LEDG-1:0]     ledg_out,
  output logic [4*HEX_DIGITS-1:0] hex_out,
  output logic                    irq
);

  localparam int HEX_W = 4 * HEX_DIGITS;

  // Writable bits of IRQ_EN: one per key plus the global switch enable.
  localparam logic [DBITS-1:0] IRQ_EN_MASK =
    (DBITS'(1) << IRQ_SW_BIT) | DBITS'((64'd1 << NUM_KEYS) - 64'd1);

  // ---------------------------------------------------------------------
  // Input conditioning
  // ---------------------------------------------------------------------
  logic [NUM_KEYS-1:0] key_norm, key_stable, key_toggle, key_rise;
  logic [NUM_SW-1:0]   sw_stable, sw_toggle;

  // Keys are flipped to 1 = pressed before synchronising, so the debouncer
  // always treats 0 as the released level.
  assign key_norm = (KEY_ACTIVE_LOW != 0) ? ~key_in : key_in;

  io_debounce #(
    .WIDTH           (NUM_KEYS),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_key_db (
    .clk    (clk),
    .reset  (reset),
    .din    (key_norm),
    .stable (key_stable),
    .toggle (key_toggle)
  );

  io_debounce #(
    .WIDTH           (NUM_SW),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_sw_db (
    .clk    (clk),
    .reset  (reset),
    .din    (sw_in),
    .stable (sw_stable),
    .toggle (sw_toggle)
  );

  // A key press is a toggle of a channel that is currently released.
  assign key_rise = key_toggle & ~key_stable;

  // ---------------------------------------------------------------------
  // Bus decode
  // ---------------------------------------------------------------------
  logic     hit;
  reg_sel_e sel;

  assign hit = (addr[DBITS-1:8] == IO_BASE[DBITS-1:8]) && (addr[1:0] == 2'b00);
  assign sel = hit ? decode_offset(addr[7:0]) : REG_NONE;

  // ---------------------------------------------------------------------
  // Register state
  // ---------------------------------------------------------------------
  logic [HEX_W-1:0]    hex_q, hex_d;
  logic [NUM_LEDR-1:0] ledr_q, ledr_d;
  logic [NUM_LEDG-1:0] ledg_q, ledg_d;
  logic [DBITS-1:0]    irq_en_q, irq_en_d;
  logic [NUM_KEYS-1:0] key_edge_q, key_edge_d, key_clr;
  logic [NUM_SW-1:0]   sw_edge_q, sw_edge_d, sw_clr;
  logic                irq_q, irq_d;
  logic [DBITS-1:0]    rdata_q, rdata_d, rd_mux;
  logic                rd_valid_q, rd_valid_d;

  // Read mux over current register contents; unused upper bits read as 0.
  always_comb begin
    rd_mux = '0;
    case (sel)
      REG_HEX:      rd_mux[HEX_W-1:0]    = hex_q;
      REG_LEDR:     rd_mux[NUM_LEDR-1:0] = ledr_q;
      REG_LEDG:     rd_mux[NUM_LEDG-1:0] = ledg_q;
      REG_KEY:      rd_mux[NUM_KEYS-1:0] = key_stable;
      REG_SW:       rd_mux[NUM_SW-1:0]   = sw_stable;
      REG_KEY_EDGE: rd_mux[NUM_KEYS-1:0] = key_edge_q;
      REG_SW_EDGE:  rd_mux[NUM_SW-1:0]   = sw_edge_q;
      REG_IRQ_EN:   rd_mux               = irq_en_q;
      default:      rd_mux               = '0;
    endcase
  end

  // Next-state for writable registers, edge capture, interrupt and read port.
  always_comb begin
    hex_d      = hex_q;
    ledr_d     = ledr_q;
    ledg_d     = ledg_q;
    irq_en_d   = irq_en_q;
    key_clr    = '0;
    sw_clr     = '0;
    if (we) begin
      case (sel)
        REG_HEX:      hex_d    = wdata[HEX_W-1:0];
        REG_LEDR:     ledr_d   = wdata[NUM_LEDR-1:0];
        REG_LEDG:     ledg_d   = wdata[NUM_LEDG-1:0];
        REG_KEY_EDGE: key_clr  = wdata[NUM_KEYS-1:0];
        REG_SW_EDGE:  sw_clr   = wdata[NUM_SW-1:0];
        REG_IRQ_EN:   irq_en_d = wdata & IRQ_EN_MASK;
        default:      ;
      endcase
    end

    // Set is OR-ed in after the clear so a same-cycle set survives.
    key_edge_d = (key_edge_q & ~key_clr) | key_rise;
    sw_edge_d  = (sw_edge_q & ~sw_clr) | sw_toggle;

    irq_d = (|(key_edge_q & irq_en_q[NUM_KEYS-1:0]))
          | (irq_en_q[IRQ_SW_BIT] & (|sw_edge_q));

    // Read returns pre-write contents and holds until the next read.
    rdata_d    = re ? rd_mux : rdata_q;
    rd_valid_d = re;
  end

  // All bus-visible state, cleared asynchronously.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hex_q      <= '0;
      ledr_q     <= '0;
      ledg_q     <= '0;
      irq_en_q   <= '0;
      key_edge_q <= '0;
      sw_edge_q  <= '0;
      irq_q      <= 1'b0;
      rdata_q    <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      hex_q      <= hex_d;
      ledr_q     <= ledr_d;
      ledg_q     <= ledg_d;
      irq_en_q   <= irq_en_d;
      key_edge_q <= key_edge_d;
      sw_edge_q  <= sw_edge_d;
      irq_q      <= irq_d;
      rdata_q    <= rdata_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  assign hex_out  = hex_q;
  assign ledr_out = ledr_q;
  assign ledg_out = ledg_q;
  assign irq      = irq_q;
  assign rdata    = rdata_q;
  assign rd_valid = rd_valid_q;

endmodule

// File: tb/tb_mmio_io_ctrl.sv
// Bench for mmio_io_ctrl with a short debounce window. A reference model
// tracks the register file; debounce is modelled as a sliding window over
// the history of sampled pin levels rather than as counters.
module tb_mmio_io_ctrl;

  localparam int          DB   = 4;
  localparam int          NK   = 4;
  localparam int          NS   = 10;
  localparam int          NR   = 10;
  localparam int          NG   = 8;
  localparam int          HD   = 4;
  localparam logic [31:0] BASE = 32'hF000_0000;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          we, re;
  logic [31:0]   addr, wdata, rdata;
  logic          rd_valid;
  logic [NK-1:0] key_in;
  logic [NS-1:0] sw_in;
  logic [NR-1:0] ledr_out;
  logic [NG-1:0] ledg_out;
  logic [4*HD-1:0] hex_out;
  logic          irq;

  int vectors = 0;
  int miscompares = 0;

  // Model state.
  logic [31:0] m_hex, m_ledr, m_ledg, m_irq_en, m_kedge, m_sedge;
  logic [31:0] m_key, m_sw, m_rdata;
  logic        m_irq, m_valid;
  logic [31:0] kq [$];
  logic [31:0] sq [$];

  mmio_io_ctrl #(
    .DBITS           (32),
    .IO_BASE         (BASE),
    .NUM_KEYS        (NK),
    .NUM_SW          (NS),
    .NUM_LEDR        (NR),
    .NUM_LEDG        (NG),
    .HEX_DIGITS      (HD),
    .KEY_ACTIVE_LOW  (1),
    .DEBOUNCE_CYCLES (DB)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .we       (we),
    .re       (re),
    .addr     (addr),
    .wdata    (wdata),
    .rdata    (rdata),
    .rd_valid (rd_valid),
    .key_in   (key_in),
    .sw_in    (sw_in),
    .ledr_out (ledr_out),
    .ledg_out (ledg_out),
    .hex_out  (hex_out),
    .irq      (irq)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mask(input int n);
    if (n >= 32) return 32'hFFFF_FFFF;
    return (32'd1 << n) - 32'd1;
  endfunction

  function automatic logic addr_hit(input logic [31:0] a);
    return (a & 32'hFFFF_FF03) == BASE;
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] a);
    if (!addr_hit(a)) return 32'h0;
    case (a & 32'hFF)
      32'h00:  return m_hex;
      32'h04:  return m_ledr;
      32'h08:  return m_ledg;
      32'h10:  return m_key;
      32'h14:  return m_sw;
      32'h18:  return m_kedge;
      32'h1C:  return m_sedge;
      32'h20:  return m_irq_en;
      default: return 32'h0;
    endcase
  endfunction

  // A channel adopts level v when the last DB synchronised samples (pin
  // samples delayed two clocks) all equal v and v differs from stable.
  function automatic logic [31:0] accept(input logic [31:0] q [$],
                                         input logic [31:0] stab,
                                         input int w);
    logic [31:0] tog;
    logic        v, all_same;
    int          newest;
    tog    = '0;
    newest = q.size() - 3;
    for (int b = 0; b < w; b++) begin
      v        = q[newest][b];
      all_same = 1'b1;
      for (int k = 0; k < DB; k++)
        if (q[newest - k][b] != v) all_same = 1'b0;
      if (all_same && (v != stab[b])) tog[b] = 1'b1;
    end
    return tog;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    check("rd_valid", {31'h0, rd_valid}, {31'h0, m_valid});
    check("rdata", rdata, m_rdata);
    check("hex_out", {16'h0, hex_out}, m_hex);
    check("ledr_out", {22'h0, ledr_out}, m_ledr);
    check("ledg_out", {24'h0, ledg_out}, m_ledg);
    check("irq", {31'h0, irq}, {31'h0, m_irq});
  endtask

  // Advance one clock: predict from pre-edge inputs, then compare after it.
  task automatic tick();
    logic [31:0] kraw, kt, st;
    logic [31:0] n_hex, n_ledr, n_ledg, n_irq_en, n_kedge, n_sedge, n_rdata;
    logic        n_irq, n_valid;
    kraw = '0;
    kraw[NK-1:0] = ~key_in;
    kq.push_back(kraw);
    sq.push_back({22'h0, sw_in});
    while (kq.size() > DB + 3) void'(kq.pop_front());
    while (sq.size() > DB + 3) void'(sq.pop_front());
    kt = accept(kq, m_key, NK);
    st = accept(sq, m_sw, NS);

    n_irq    = (|(m_kedge & m_irq_en & mask(NK))) | (m_irq_en[31] & (|m_sedge));
    n_rdata  = re ? model_read(addr) : m_rdata;
    n_valid  = re;
    n_hex    = m_hex;
    n_ledr   = m_ledr;
    n_ledg   = m_ledg;
    n_irq_en = m_irq_en;
    n_kedge  = m_kedge | (kt & ~m_key);
    n_sedge  = m_sedge | st;
    if (we && addr_hit(addr)) begin
      case (addr & 32'hFF)
        32'h00: n_hex    = wdata & mask(4 * HD);
        32'h04: n_ledr   = wdata & mask(NR);
        32'h08: n_ledg   = wdata & mask(NG);
        32'h18: n_kedge  = (m_kedge & ~wdata) | (kt & ~m_key);
        32'h1C: n_sedge  = (m_sedge & ~wdata) | st;
        32'h20: n_irq_en = wdata & (mask(NK) | 32'h8000_0000);
        default: ;
      endcase
    end

    @(posedge clk);
    m_hex = n_hex;  m_ledr = n_ledr;  m_ledg = n_ledg;  m_irq_en = n_irq_en;
    m_kedge = n_kedge;  m_sedge = n_sedge;  m_irq = n_irq;
    m_rdata = n_rdata;  m_valid = n_valid;
    m_key = m_key ^ kt;
    m_sw  = m_sw ^ st;
    #1;
    check_outputs();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    m_hex = 0; m_ledr = 0; m_ledg = 0; m_irq_en = 0; m_kedge = 0; m_sedge = 0;
    m_key = 0; m_sw = 0; m_rdata = 0; m_irq = 1'b0; m_valid = 1'b0;
    kq.delete();
    sq.delete();
    for (int i = 0; i < DB + 2; i++) begin
      kq.push_back(32'h0);
      sq.push_back(32'h0);
    end
    #1;
    check("rst_rdata", rdata, 32'h0);
    check("rst_rd_valid", {31'h0, rd_valid}, 32'h0);
    check("rst_hex", {16'h0, hex_out}, 32'h0);
    check("rst_ledr", {22'h0, ledr_out}, 32'h0);
    check("rst_ledg", {24'h0, ledg_out}, 32'h0);
    check("rst_irq", {31'h0, irq}, 32'h0);
    #1;
    reset = 1'b0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    addr = a; wdata = d; we = 1'b1;
    tick();
    we = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] exp, input string tag);
    addr = a; re = 1'b1;
    tick();
    re = 1'b0;
    check(tag, rdata, exp);
    check({tag, "_valid"}, {31'h0, rd_valid}, 32'h1);
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    case ($urandom_range(0, 11))
      0:  a = BASE + 32'h00;
      1:  a = BASE + 32'h04;
      2:  a = BASE + 32'h08;
      3:  a = BASE + 32'h10;
      4:  a = BASE + 32'h14;
      5:  a = BASE + 32'h18;
      6:  a = BASE + 32'h1C;
      7:  a = BASE + 32'h20;
      8:  a = BASE + 32'h20;
      9:  a = BASE + 32'($urandom_range(1, 3)) + 32'($urandom_range(0, 8) * 4);
      10: a = BASE + 32'h40;
      default: a = $urandom;
    endcase
    return a;
  endfunction

  initial begin
    we = 1'b0; re = 1'b0; addr = '0; wdata = '0;
    key_in = '1; sw_in = '0;
    #1;
    do_reset();

    // Every register reads 0 after reset; rd_valid drops after the last read.
    rd(BASE + 32'h00, 32'h0, "rst_rd_hex");
    rd(BASE + 32'h04, 32'h0, "rst_rd_ledr");
    rd(BASE + 32'h08, 32'h0, "rst_rd_ledg");
    rd(BASE + 32'h10, 32'h0, "rst_rd_key");
    rd(BASE + 32'h14, 32'h0, "rst_rd_sw");
    rd(BASE + 32'h18, 32'h0, "rst_rd_kedge");
    rd(BASE + 32'h1C, 32'h0, "rst_rd_sedge");
    rd(BASE + 32'h20, 32'h0, "rst_rd_irq_en");
    tick();
    check("rd_valid_drop", {31'h0, rd_valid}, 32'h0);

    // Output registers and truncation.
    wr(BASE + 32'h00, 32'h0000_1234);
    check("hex_write", {16'h0, hex_out}, 32'h1234);
    wr(BASE + 32'h04, 32'hFFFF_FFFF);
    check("ledr_write", {22'h0, ledr_out}, 32'h3FF);
    rd(BASE + 32'h04, 32'h0000_03FF, "ledr_readback");

    // Key 2 press: accepted 2+DB clocks after the pin edge.
    key_in[2] = 1'b0;
    repeat (5) tick();
    rd(BASE + 32'h10, 32'h0, "key_before_accept");
    rd(BASE + 32'h10, 32'h4, "key_accepted");
    key_in[2] = 1'b1;
    rd(BASE + 32'h18, 32'h4, "kedge_press");
    // 3-clock glitch on key 1 is filtered.
    key_in[1] = 1'b0;
    repeat (3) tick();
    key_in[1] = 1'b1;
    repeat (8) tick();
    rd(BASE + 32'h10, 32'h0, "key_after_glitch");
    rd(BASE + 32'h18, 32'h4, "kedge_after_glitch");

    // Interrupt on key 2.
    wr(BASE + 32'h18, 32'hF);
    wr(BASE + 32'h20, 32'h4);
    tick();
    check("irq_idle", {31'h0, irq}, 32'h0);
    key_in[2] = 1'b0;
    repeat (6) tick();
    check("irq_same_edge_as_bit", {31'h0, irq}, 32'h0);
    tick();
    check("irq_rise", {31'h0, irq}, 32'h1);
    wr(BASE + 32'h18, 32'h0);
    tick();
    check("irq_write0_keeps", {31'h0, irq}, 32'h1);
    wr(BASE + 32'h18, 32'h4);
    check("irq_clear_edge", {31'h0, irq}, 32'h1);
    tick();
    check("irq_fall", {31'h0, irq}, 32'h0);
    key_in[2] = 1'b1;
    repeat (8) tick();

    // Clear and set of KEY_EDGE[0] in the same cycle: set wins.
    key_in[0] = 1'b0;
    repeat (5) tick();
    wr(BASE + 32'h18, 32'h1);
    key_in[0] = 1'b1;
    rd(BASE + 32'h18, 32'h1, "kedge_set_wins");
    repeat (8) tick();

    // Reset mid-debounce discards the pending switch change.
    sw_in[3] = 1'b1;
    repeat (4) tick();
    do_reset();
    rd(BASE + 32'h14, 32'h0, "sw_after_reset");
    repeat (5) tick();
    rd(BASE + 32'h14, 32'h8, "sw_redebounced");
    rd(BASE + 32'h1C, 32'h8, "sedge_after_reset");

    // Misaligned and unmapped accesses.
    wr(BASE + 32'h02, 32'hFFFF_FFFF);
    check("misaligned_write", {16'h0, hex_out}, 32'h0);
    rd(BASE + 32'h02, 32'h0, "misaligned_read");
    rd(BASE + 32'h24, 32'h0, "unmapped_read");
    wr(32'hE000_0004, 32'hFFFF_FFFF);
    check("outside_write", {22'h0, ledr_out}, 32'h0);
    rd(32'hE000_0004, 32'h0, "outside_read");

    // Randomised traffic and pin activity against the model.
    for (int i = 0; i < 800; i++) begin
      we    = ($urandom_range(0, 3) == 0);
      re    = $urandom_range(0, 1) != 0;
      addr  = rand_addr();
      wdata = $urandom;
      if ($urandom_range(0, 7) == 0) key_in[$urandom_range(0, NK - 1)] ^= 1'b1;
      if ($urandom_range(0, 7) == 0) sw_in[$urandom_range(0, NS - 1)] ^= 1'b1;
      tick();
      if (i == 400) begin
        we = 1'b0; re = 1'b0;
        do_reset();
      end
    end
    we = 1'b0; re = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mmio_io_ctrl.md
Name: mmio_io_ctrl

Overview:
- Parametrised memory-mapped I/O controller for the board peripherals: KEY, SW, HEX, LEDR and LEDG.
- Sits on the CPU data-memory bus beside data RAM. The CPU decodes nothing; this block claims its own addresses.
- Adds three things beyond plain I/O registers: input synchronisation and debouncing, sticky edge-capture registers, and a level interrupt.
- Peripheral counts and widths are parameters, so the block scales to other boards.

Parameters:
- DBITS, 32, bus address and data width.
- IO_BASE, 32'hF0000000, base address of the register window.
- NUM_KEYS, 4, number of push-button channels (1..32).
- NUM_SW, 10, number of switch channels (1..32).
- NUM_LEDR, 10, width of the red LED register (1..32).
- NUM_LEDG, 8, width of the green LED register (1..32).
- HEX_DIGITS, 4, number of 4-bit hex digits driven (1..8).
- KEY_ACTIVE_LOW, 1, when 1 a raw KEY level of 0 means pressed.
- DEBOUNCE_CYCLES, 50000, number of consecutive clocks an input must hold a new level before it is accepted (at least 1).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- we  in  1  write strobe, sampled on the rising edge of clk.
- re  in  1  read strobe.
- addr  in  DBITS  byte address.
- wdata  in  DBITS  write data.
- rdata  out  DBITS  registered read data.
- rd_valid  out  1  high for exactly one cycle when rdata is valid.
- key_in  in  NUM_KEYS  raw, asynchronous button pins.
- sw_in  in  NUM_SW  raw, asynchronous switch pins.
- ledr_out  out  NUM_LEDR  red LED drive.
- ledg_out  out  NUM_LEDG  green LED drive.
- hex_out  out  4*HEX_DIGITS  hex nibbles; digit 0 occupies [3:0].
- irq  out  1  level interrupt request.

Behaviour:
- Register map (offset from IO_BASE):
  - 0x00 HEX, read/write.
  - 0x04 LEDR, read/write.
  - 0x08 LEDG, read/write.
  - 0x10 KEY, read-only; debounced, 1 = pressed.
  - 0x14 SW, read-only; debounced.
  - 0x18 KEY_EDGE, write-1-to-clear.
  - 0x1C SW_EDGE, write-1-to-clear.
  - 0x20 IRQ_EN, read/write; bits [NUM_KEYS-1:0] enable keys, bit 31 enables all switch edges.
- Address hit: addr[DBITS-1:8] == IO_BASE[DBITS-1:8] and addr[1:0] == 0. Misaligned or unmapped accesses are ignored; a read of such an address returns 0 with rd_valid still asserted.
- Writes take effect at the clock edge where we=1.
  - Data is truncated to the register width; unused read bits return 0.
  - Writes to KEY and SW are ignored.
- Reads have 1-cycle latency: re=1 at edge N gives rdata and rd_valid at edge N+1. rdata holds its value until the next read. If we and re are both high, the read returns the pre-write value.
- Input path, per channel:
  - 2-FF synchroniser, then debounce.
  - Debounce counter: reset to 0 whenever the synchronised value equals the stable value; incremented otherwise.
  - When the counter reaches DEBOUNCE_CYCLES-1 while still differing, the stable value takes the synchronised value and the counter clears.
  - Pin-to-stable latency is 2 + DEBOUNCE_CYCLES clocks.
  - A glitch shorter than DEBOUNCE_CYCLES clocks never changes the stable value.
  - The KEY stable value is normalised so that 1 = pressed, whatever KEY_ACTIVE_LOW is.
- Edge capture:
  - A KEY_EDGE bit sets on a 0->1 transition of the stable (pressed) value.
  - A SW_EDGE bit sets on any change of the stable value.
  - Bits are sticky. Writing 1 clears a bit; writing 0 has no effect.
  - If a set and a clear happen in the same cycle, the set wins.
- irq is registered: at each edge, irq <= |(KEY_EDGE & IRQ_EN[NUM_KEYS-1:0]) | (IRQ_EN[31] & |SW_EDGE). It rises 1 clock after the edge bit sets and falls 1 clock after the clear.
- Reset is asynchronous and affects everything immediately:
  - All output registers, edge bits, IRQ_EN, rdata, rd_valid and irq go to 0.
  - Stable values go to 0 (released / switch-low) and debounce counters go to 0.
  - Synchroniser FFs go to the inactive raw level: 1 for keys when KEY_ACTIVE_LOW=1, otherwise 0.
  - A reset mid-debounce discards the pending change.
  - After reset release, switches already high are detected through normal debouncing and set SW_EDGE.

Decomposition:
- Package io_pkg holds:
  - Register offset constants: OFF_HEX, OFF_LEDR, OFF_LEDG, OFF_KEY, OFF_SW, OFF_KEY_EDGE, OFF_SW_EDGE, OFF_IRQ_EN.
  - IRQ_SW_BIT = 31.
- One sub-module, io_debounce:
  - Parameters WIDTH and DEBOUNCE_CYCLES.
  - Contains the synchroniser, per-bit counters and stable register.
  - Instantiated once for keys and once for switches; polarity inversion happens in the parent.

Test Plan (DEBOUNCE_CYCLES=4 unless noted):
1. Reset, then read each register -> every read returns 0; rd_valid pulses once per read; ledr_out=0, hex_out=0, irq=0.
2. Write 0x1234 to offset 0x00 and 0xFFFFFFFF to 0x04 -> hex_out=0x1234 and ledr_out=0x3FF on the next edge; reading 0x04 returns 0x000003FF.
3. key_in[2] driven 1->0 (active low) for 6 clocks:
   - KEY reads 0x4 from 2+4 clocks after the pin edge.
   - KEY_EDGE=0x4.
   - A 3-clock glitch on key_in[1] leaves KEY and KEY_EDGE bit 1 unchanged.
4. IRQ_EN=0x4, then press key 2 -> irq rises 1 clock after KEY_EDGE[2] sets; writing 0x4 to 0x18 clears the bit and irq falls 1 clock later; writing 0x0 leaves it set.
5. Write 1 to clear KEY_EDGE[0] in the same cycle a new key-0 press is accepted -> the bit reads 1.
6. Assert reset while sw_in[3] is 2 clocks into debouncing -> SW stays 0. After release, SW[3] becomes 1 and SW_EDGE[3]=1 after 2+4 clocks. An access to 0xF0000002 changes no state and reads 0.
